stream_token_source: RTL and testbench
======================================

// Module: stream_token_source
// PURPOSE
//   Transmit side of the CGRA valid/ready token channel: replays a preloaded token table into a
//   downstream FIFO input (din/din_v/din_r). Host loads the table through a config port, pulses
//   start with base/length, and the block streams tokens at up to 1 token/cycle, then pulses done.
// PARAMETERS
//   DATA_WIDTH  32  token width
//   MEM_DEPTH   32  token table entries (power of two)
//   ADDR_WIDTH  5   log2(MEM_DEPTH)
// PORTS
//   clock       in   1             single clock, all logic on posedge
//   reset       in   1             synchronous, active-low (reset==0 clears state at posedge)
//   cfg_we      in   1             table write strobe
//   cfg_addr    in   ADDR_WIDTH    table write address
//   cfg_data    in   DATA_WIDTH    table write data
//   start       in   1             one-cycle run request
//   base_addr   in   ADDR_WIDTH    first table index, sampled on accepted start
//   length      in   ADDR_WIDTH+1  tokens to send (0..MEM_DEPTH), sampled on accepted start
//   dout        out  DATA_WIDTH    token to downstream (connects to FIFO din)
//   dout_v      out  1             token valid (connects to FIFO din_v)
//   dout_r      in   1             downstream ready (connects to FIFO din_r)
//   busy        out  1             run in progress
//   done        out  1             one-cycle pulse after last token handshaked
// BEHAVIOUR
//   - Reset (reset==0): dout=0, dout_v=0, busy=0, done=0, FSM->IDLE, counters/buffer cleared.
//     Table contents are NOT cleared. Reset mid-run aborts: no done pulse, buffered tokens dropped.
//   - Handshake: transfer when dout_v & dout_r at posedge. Once dout_v=1, dout and dout_v hold
//     stable until transfer. dout_v never depends combinationally on dout_r.
//   - Table: synchronous write (cfg_we) and synchronous read (data valid one cycle after address).
//     cfg_we while busy is ignored (table frozen during a run).
//   - FSM: IDLE -> (start) RUN -> (last token transferred) DONE -> IDLE.
//     IDLE: busy=0; start with length=0 -> DONE directly (done pulses next cycle, no tokens).
//     RUN: busy=1; start ignored. DONE: done=1 for exactly one cycle, busy=0.
//   - Read issue: rd_addr starts at base_addr, increments by 1, wraps modulo MEM_DEPTH
//     (base=30,len=4 -> 30,31,0,1). issue_cnt counts reads issued, stops at length.
//   - Buffering: 2-entry output buffer (head drives dout). A read is issued only if
//     (entries + reads in flight) < 2 after this cycle's pop; guarantees no overflow on stall.
//   - Latency: start accepted at cycle T -> first dout_v=1 at T+2. With dout_r held 1,
//     one token per cycle thereafter; last transfer at T+1+length; done=1 at T+2+length.
//   - Stall: dout_r=0 at any point halts transfers; no token lost, duplicated or reordered;
//     resumes at full rate when dout_r returns to 1.
//   - sent_cnt (ADDR_WIDTH+1 bits) increments per transfer; RUN exits when sent_cnt==length.
//   - Simultaneous start and done-cycle: start in DONE state is ignored (accepted only in IDLE).
// STRUCTURE
//   - Shared package: channel state enum {IDLE,RUN,DONE}, DATA_WIDTH default constant.
//   - One sub-module: token_table_ram (1W/1R synchronous RAM, MEM_DEPTH x DATA_WIDTH).
//   - Top holds FSM, issue/sent counters, 2-entry output buffer.
// TESTING
//   1. Load table[i]=32'hA000_0000+i; start base=0,len=4, dout_r=1 -> A0000000..A0000003 on
//      consecutive cycles, first dout_v at T+2, done at T+6, busy low after.
//   2. base=30,len=4 -> tokens A000001E,A000001F,A0000000,A0000001 (wrap).
//   3. len=8, dout_r toggles 1,0,0,1 pattern -> exactly 8 transfers in order, dout stable while
//      stalled, done one cycle after 8th transfer.
//   4. len=0 -> dout_v never rises, done pulses once, busy stays 0.
//   5. reset=0 during run after 3 transfers -> next cycle dout_v=0,busy=0, no done; new start
//      base=0,len=2 replays A0000000,A0000001.
//   6. cfg_we to addr 1 with 32'hDEAD_BEEF while busy -> ignored; later run shows A0000001.

Source files
------------

// File: rtl/stream_token_source_pkg.sv
// Shared definitions for the CGRA token source: channel FSM states and default sizes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package stream_token_source_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int MEM_DEPTH_DEF  = 32;
    localparam int ADDR_WIDTH_DEF = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } chan_state_e;

endpackage

// File: rtl/stream_token_source_if.sv
// Valid/ready token channel between the token source and a downstream FIFO input.
// Latency: n/a (wires only).
// Backpressure: master holds dout/dout_v stable until dout_r is seen at a clock edge.
// Ports: dout (token), dout_v (token valid), dout_r (downstream ready).
interface stream_token_source_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] dout;
    logic                  dout_v;
    logic                  dout_r;

    modport master (output dout, output dout_v, input dout_r);
    modport slave  (input dout, input dout_v, output dout_r);
endinterface

// File: rtl/stream_token_source_token_table_ram.sv
// Token table: 1 write / 1 read port synchronous RAM, MEM_DEPTH x DATA_WIDTH.
// Latency: read data valid one cycle after re/raddr are presented.
// Backpressure: none; contents are not cleared by reset.
// Ports: clock, we/waddr/wdata (write), re/raddr (read request), rdata (registered read data).
module token_table_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clock,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/stream_token_source.sv
// Replays a preloaded token table (base/length window, wrapping) onto a valid/ready channel.
// Latency: start accepted at T -> first dout_v at T+2, then 1 token/cycle; done one cycle after last transfer.
// Backpressure: dout_r=0 stalls; 2-entry output buffer with read-issue throttling never overflows.
// Ports: clock/reset (sync, active-low), cfg_* table write, start/base_addr/length run request,
//        tok (master side of the token channel), busy (run in progress), done (1-cycle pulse).
module stream_token_source
    import stream_token_source_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int MEM_DEPTH  = MEM_DEPTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cfg_we,
    input  logic [ADDR_WIDTH-1:0] cfg_addr,
    input  logic [DATA_WIDTH-1:0] cfg_data,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    stream_token_source_if.master tok,
    output logic                  busy,
    output logic                  done
);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

    chan_state_e           state_q, state_d;
    logic [ADDR_WIDTH:0]   len_q, len_d;
    logic [ADDR_WIDTH:0]   issue_cnt_q, issue_cnt_d;
    logic [ADDR_WIDTH:0]   sent_cnt_q, sent_cnt_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                  pend_q, pend_d;
    logic [DATA_WIDTH-1:0] buf_q [2];
    logic [DATA_WIDTH-1:0] buf_d [2];
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [1:0]            cnt_q, cnt_d;

    logic                  start_acc;
    logic                  pop;
    logic                  ram_we;
    logic                  ram_re;
    logic [ADDR_WIDTH-1:0] ram_raddr;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic [1:0]            occ_after_pop;

    assign start_acc = (state_q == IDLE) && start;
    assign pop       = tok.dout_v && tok.dout_r;
    // Table is frozen while tokens are being streamed.
    assign ram_we    = cfg_we && (state_q != RUN);

    assign tok.dout_v = (cnt_q != 2'd0);
    assign tok.dout   = buf_q[rd_ptr_q];

    token_table_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_table (
        .clock (clock),
        .we    (ram_we),
        .waddr (cfg_addr),
        .wdata (cfg_data),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    // FSM state register
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (length == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (pop && ((sent_cnt_q + CNT_ONE) == len_q)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
    end

    // Read issue, output buffer and counters
    always_comb begin
        len_d       = len_q;
        issue_cnt_d = issue_cnt_q;
        sent_cnt_d  = sent_cnt_q;
        rd_addr_d   = rd_addr_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        buf_d       = buf_q;
        ram_re      = 1'b0;
        ram_raddr   = rd_addr_q;

        // Occupancy once this cycle's pop and the in-flight read have landed; a new
        // read is only allowed if it will still find a free slot.
        occ_after_pop = cnt_q - {1'b0, pop} + {1'b0, pend_q};

        if (start_acc) begin
            // The first read goes out in the accept cycle so data reaches the buffer by T+2.
            len_d       = length;
            sent_cnt_d  = '0;
            issue_cnt_d = '0;
            rd_addr_d   = base_addr;
            if (length != '0) begin
                ram_re      = 1'b1;
                ram_raddr   = base_addr;
                rd_addr_d   = base_addr + ADDR_ONE;
                issue_cnt_d = CNT_ONE;
            end
        end else if ((state_q == RUN) && (issue_cnt_q != len_q) && (occ_after_pop < 2'd2)) begin
            ram_re      = 1'b1;
            rd_addr_d   = rd_addr_q + ADDR_ONE;   // wraps modulo MEM_DEPTH
            issue_cnt_d = issue_cnt_q + CNT_ONE;
        end

        pend_d = ram_re;

        if (pend_q) begin
            buf_d[wr_ptr_q] = ram_rdata;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d   = ~rd_ptr_q;
            sent_cnt_d = sent_cnt_q + CNT_ONE;
        end
        cnt_d = cnt_q + {1'b0, pend_q} - {1'b0, pop};
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            len_q       <= '0;
            issue_cnt_q <= '0;
            sent_cnt_q  <= '0;
            rd_addr_q   <= '0;
            pend_q      <= 1'b0;
            buf_q[0]    <= '0;
            buf_q[1]    <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            cnt_q       <= 2'd0;
        end else begin
            len_q       <= len_d;
            issue_cnt_q <= issue_cnt_d;
            sent_cnt_q  <= sent_cnt_d;
            rd_addr_q   <= rd_addr_d;
            pend_q      <= pend_d;
            buf_q       <= buf_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
        end
    end
endmodule

// File: tb/tb_stream_token_source.sv
// Bench for stream_token_source: directed runs (wrap, stall pattern, zero length,
// mid-run reset, frozen table) followed by randomized runs against a table model.
// Outputs are sampled on the falling edge; dout_r is chosen on that same edge.
module tb_stream_token_source;
    import stream_token_source_pkg::*;

    localparam int DW    = 32;
    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          cfg_we = 1'b0;
    logic [AW-1:0] cfg_addr = '0;
    logic [DW-1:0] cfg_data = '0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   length = '0;
    logic          busy;
    logic          done;

    stream_token_source_if #(.DATA_WIDTH(DW)) tok ();

    stream_token_source #(
        .DATA_WIDTH (DW),
        .MEM_DEPTH  (DEPTH),
        .ADDR_WIDTH (AW)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .tok       (tok),
        .busy      (busy),
        .done      (done)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference copy of the token table.
    logic [DW-1:0] tbl [DEPTH];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic write_tbl(input int addr, input logic [DW-1:0] data);
        @(negedge clock);
        cfg_we   = 1'b1;
        cfg_addr = AW'(addr);
        cfg_data = data;
        @(negedge clock);
        cfg_we   = 1'b0;
    endtask

    // mode: 0 = ready always high, 1 = ready pattern 1,0,0,1, 2 = random ready.
    // abort_after >= 0: pull reset low once that many transfers have completed.
    // inject: attempt a table write to address 1 while the run is busy.
    task automatic run_job(input int base, input int len, input int mode,
                           input int abort_after, input bit inject);
        logic [DW-1:0] expq [$];
        logic [DW-1:0] prev_d;
        bit            pat [4];
        bit            prev_v, prev_x, r, x, finished;
        int            xfers, last_c, c;

        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < len; i++) expq.push_back(tbl[(base + i) % DEPTH]);

        @(negedge clock);
        start      = 1'b1;
        base_addr  = AW'(base);
        length     = (AW+1)'(len);
        tok.dout_r = 1'b0;
        @(negedge clock);
        start = 1'b0;

        xfers = 0; last_c = 0; prev_v = 0; prev_x = 0; prev_d = '0; finished = 0; c = 0;
        while (!finished) begin
            c++;
            if (c > 1) @(negedge clock);

            if (inject && c == 2) begin
                cfg_we = 1'b1; cfg_addr = AW'(1); cfg_data = 32'hDEAD_BEEF;
            end
            if (inject && c == 3) cfg_we = 1'b0;

            if (abort_after >= 0 && xfers == abort_after) begin
                reset = 1'b0;
                tok.dout_r = 1'b0;
                @(negedge clock);
                reset = 1'b1;
                chk("abort_dout_v", tok.dout_v, 0);
                chk("abort_busy", busy, 0);
                chk("abort_done", done, 0);
                for (int k = 0; k < 6; k++) begin
                    @(negedge clock);
                    chk("abort_no_done", done, 0);
                    chk("abort_idle_v", tok.dout_v, 0);
                end
                finished = 1;
            end else if (c > 300) begin
                chk("timeout", 0, 1);
                finished = 1;
            end else if (done) begin
                chk("done_cycle", c, (len == 0) ? 1 : last_c + 1);
                if (mode == 0) chk("done_latency", c, (len == 0) ? 1 : len + 2);
                chk("sent_count", xfers, len);
                chk("busy_in_done", busy, 0);
                chk("v_in_done", tok.dout_v, 0);
                @(negedge clock);
                chk("done_one_cycle", done, 0);
                chk("busy_after", busy, 0);
                finished = 1;
            end else begin
                if (c == 1) chk("v_at_T1", tok.dout_v, 0);
                if (mode == 0 && len > 0 && c == 2) chk("v_at_T2", tok.dout_v, 1);
                if (prev_v && !prev_x) begin
                    chk("hold_v", tok.dout_v, 1);
                    chk("hold_dout", tok.dout, prev_d);
                end
                chk("busy_run", busy, (xfers < len) ? 1 : 0);
                if (tok.dout_v) begin
                    if (expq.size() == 0) chk("extra_token", 1, 0);
                    else chk("dout", tok.dout, expq[0]);
                end

                case (mode)
                    0:       r = 1'b1;
                    1:       r = pat[(c - 1) % 4];
                    default: r = ($urandom_range(0, 3) != 0);
                endcase
                tok.dout_r = r;
                x = tok.dout_v && r;
                if (x) begin
                    if (expq.size() != 0) void'(expq.pop_front());
                    xfers++;
                    last_c = c;
                end
                prev_v = tok.dout_v;
                prev_x = x;
                prev_d = tok.dout;
            end
        end
        tok.dout_r = 1'b0;
    endtask

    initial begin
        tok.dout_r = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        chk("rst_dout", tok.dout, 0);
        chk("rst_dout_v", tok.dout_v, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);

        for (int i = 0; i < DEPTH; i++) begin
            tbl[i] = 32'hA000_0000 + i;
            write_tbl(i, tbl[i]);
        end

        run_job(0, 4, 0, -1, 1'b0);    // basic full rate
        run_job(30, 4, 0, -1, 1'b0);   // wrap 30,31,0,1
        run_job(0, 8, 1, -1, 1'b0);    // stall pattern
        run_job(5, 0, 0, -1, 1'b0);    // zero length
        run_job(0, 8, 0, 3, 1'b0);     // reset after 3 transfers
        run_job(0, 2, 0, -1, 1'b0);    // replay after abort
        run_job(0, 8, 0, -1, 1'b1);    // write while busy is dropped
        run_job(1, 1, 0, -1, 1'b0);    // table entry 1 unchanged
        run_job(0, 32, 0, -1, 1'b0);   // full table

        for (int n = 0; n < 25; n++) begin
            if ($urandom_range(0, 1) == 1) begin
                int a;
                a = $urandom_range(0, DEPTH - 1);
                tbl[a] = $urandom;
                write_tbl(a, tbl[a]);
            end
            run_job($urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH),
                    ($urandom_range(0, 2) == 0) ? 0 : 2, -1, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
